// File: rtl/mem_master_1rw_if.sv
// mem_master_1rw_if: request, response and memory-side bus of mem_master_1rw (master = front-end, slave = environment)
interface mem_master_1rw_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int WORD_BYTES = 8
);
  logic                    req_val;
  logic                    req_rdy;
  logic                    req_we;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [8*WORD_BYTES-1:0] req_wdata;
  logic [WORD_BYTES-1:0]   req_be;
  logic                    rsp_val;
  logic                    rsp_rdy;
  logic [8*WORD_BYTES-1:0] rsp_data;
  logic                    err_addr;
  logic                    mem_ce;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [8*WORD_BYTES-1:0] mem_wr_data;
  logic [WORD_BYTES-1:0]   mem_be;
  logic [8*WORD_BYTES-1:0] mem_rd_data;
  modport master (
    input  req_val, req_we, req_addr, req_wdata, req_be, rsp_rdy, mem_rd_data,
    output req_rdy, rsp_val, rsp_data, err_addr, mem_ce, mem_we, mem_addr, mem_wr_data, mem_be
  );
  modport slave (
    output req_val, req_we, req_addr, req_wdata, req_be, rsp_rdy, mem_rd_data,
    input  req_rdy, rsp_val, rsp_data, err_addr, mem_ce, mem_we, mem_addr, mem_wr_data, mem_be
  );
endinterface

// File: rtl/mem_master_1rw.sv
// mem_master_1rw: valid/ready front-end for a 1RW sync memory with a 2-entry in-order read response buffer; MEM_MASTER_ADDR_CHK_EN drops out-of-range requests
module mem_master_1rw #(
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int WORD_BYTES = 8
) (
  input logic              clk,
  input logic              rst_n,
  mem_master_1rw_if.master bus
);
  localparam int DW = 8 * WORD_BYTES;
  if (MEM_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("MEM_DEPTH exceeds the address space");
  end
  logic [DW-1:0] fifo_q [2];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    cnt;
  logic          inflight;
  logic          oor_q;
  logic [1:0]    occ;
  logic          pop;
  logic          push;
  logic          acc;
  logic          acc_rd;
  logic          fwd;
  logic          in_range;
`ifdef MEM_MASTER_ADDR_CHK_EN
  logic          err_q;
  assign in_range     = 32'(bus.req_addr) < MEM_DEPTH;
  assign bus.err_addr = err_q;
`else
  assign in_range     = 1'b1;
  assign bus.err_addr = 1'b0;
`endif
  // a slot is free when stored + in-flight reads leave room, or when the head leaves this edge
  assign occ         = cnt + {1'b0, inflight};
  assign pop         = bus.rsp_val & bus.rsp_rdy;
  assign push        = inflight;
  assign bus.req_rdy = rst_n & ((occ < 2'd2) | pop);
  assign acc         = bus.req_val & bus.req_rdy;
  assign acc_rd      = acc & ~bus.req_we;
  assign fwd         = acc & in_range;
  assign bus.rsp_val = cnt != 2'd0;
  assign bus.rsp_data = fifo_q[rd_ptr];
  // memory port follows the accepted request combinationally, zero otherwise
  always_comb begin
    bus.mem_ce      = fwd;
    bus.mem_we      = fwd & bus.req_we;
    bus.mem_addr    = fwd ? bus.req_addr : '0;
    bus.mem_wr_data = fwd ? bus.req_wdata : '0;
    bus.mem_be      = fwd ? bus.req_be : '0;
  end
  // read tracking and buffer pointers; a dropped read returns zeros to keep the response count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      oor_q    <= 1'b0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      cnt      <= 2'd0;
    end else begin
      inflight <= acc_rd;
      oor_q    <= acc_rd & ~in_range;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
      cnt      <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end
  // response storage captures the registered memory output one edge after the read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else if (push) begin
      fifo_q[wr_ptr] <= oor_q ? '0 : bus.mem_rd_data;
    end
  end
`ifdef MEM_MASTER_ADDR_CHK_EN
  // one-cycle error pulse for each dropped request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= acc & ~in_range;
  end
`endif
  // the credit rule makes a push into a full buffer impossible
  always @(posedge clk) begin
    if (rst_n) assert (!(push && !pop && cnt == 2'd2));
  end
endmodule

// File: tb/tb_mem_master_1rw.sv
// tb_mem_master_1rw: directed self-checking bench for mem_master_1rw with a behavioural 1RW memory
module tb_mem_master_1rw;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  logic [63:0] mem [256];
  localparam logic [63:0] W5 = 64'h1122334455667788;
  mem_master_1rw_if #(.ADDR_WIDTH(8), .WORD_BYTES(8)) bus ();
  mem_master_1rw #(.ADDR_WIDTH(8), .MEM_DEPTH(200), .WORD_BYTES(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] pat(input logic [7:0] a);
    return {8{a}} ^ 64'h0123456789ABCDEF;
  endfunction
  always @(posedge clk) begin
    if (bus.mem_ce) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 8; b++)
          if (bus.mem_be[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wr_data[8*b +: 8];
      end else begin
        bus.mem_rd_data <= mem[bus.mem_addr];
      end
    end
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic v, input logic we, input logic [7:0] a, input logic [63:0] d);
    bus.req_val = v;
    bus.req_we = we;
    bus.req_addr = a;
    bus.req_wdata = d;
    bus.req_be = 8'hFF;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = pat(8'(i));
    bus.mem_rd_data = '0;
    bus.rsp_rdy = 1'b0;
    drive(1'b0, 1'b0, 8'd0, 64'd0);
    // reset and idle
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_rdy", 64'(bus.req_rdy), 64'd0);
    chk("rst_rsp_val", 64'(bus.rsp_val), 64'd0);
    chk("rst_rsp_data", bus.rsp_data, 64'd0);
    chk("rst_err", 64'(bus.err_addr), 64'd0);
    chk("rst_mem", {bus.mem_ce, bus.mem_we, bus.mem_addr, bus.mem_be}, 64'd0);
    chk("rst_mem_wd", bus.mem_wr_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_req_rdy", 64'(bus.req_rdy), 64'd1);
    chk("idle_mem_ce", 64'(bus.mem_ce), 64'd0);
    // write then read addr 5
    @(negedge clk);
    drive(1'b1, 1'b1, 8'd5, W5);
    #1;
    chk("wr_ce_we", {bus.mem_ce, bus.mem_we}, 64'd3);
    chk("wr_addr", 64'(bus.mem_addr), 64'd5);
    chk("wr_data", bus.mem_wr_data, W5);
    @(negedge clk);
    drive(1'b1, 1'b0, 8'd5, 64'd0);
    bus.rsp_rdy = 1'b1;
    #1;
    chk("rd_ce_we", {bus.mem_ce, bus.mem_we}, 64'd2);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'd0, 64'd0);
    chk("rd5_lat1", 64'(bus.rsp_val), 64'd0);
    @(negedge clk);
    chk("rd5_val", 64'(bus.rsp_val), 64'd1);
    chk("rd5_data", bus.rsp_data, W5);
    @(negedge clk);
    chk("rd5_popped", 64'(bus.rsp_val), 64'd0);
    // back-to-back reads 0..7
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i < 8) drive(1'b1, 1'b0, 8'(i), 64'd0);
      else drive(1'b0, 1'b0, 8'd0, 64'd0);
      #1;
      if (i < 8) chk($sformatf("b2b_rdy%0d", i), 64'(bus.req_rdy), 64'd1);
      if (i >= 2) begin
        chk($sformatf("b2b_val%0d", i - 2), 64'(bus.rsp_val), 64'd1);
        chk($sformatf("b2b_data%0d", i - 2), bus.rsp_data, (i - 2 == 5) ? W5 : pat(8'(i - 2)));
      end
    end
    @(negedge clk);
    chk("b2b_drained", 64'(bus.rsp_val), 64'd0);
    // stalled consumer: only two reads fit
    bus.rsp_rdy = 1'b0;
    drive(1'b1, 1'b0, 8'd10, 64'd0);
    #1;
    chk("st_rdy10", 64'(bus.req_rdy), 64'd1);
    @(negedge clk);
    drive(1'b1, 1'b0, 8'd11, 64'd0);
    #1;
    chk("st_rdy11", 64'(bus.req_rdy), 64'd1);
    @(negedge clk);
    drive(1'b1, 1'b0, 8'd12, 64'd0);
    #1;
    chk("st_rdy12_blocked", 64'(bus.req_rdy), 64'd0);
    chk("st_ce_blocked", 64'(bus.mem_ce), 64'd0);
    @(negedge clk);
    chk("st_still_blocked", 64'(bus.req_rdy), 64'd0);
    chk("st_head10", bus.rsp_data, pat(8'd10));
    bus.rsp_rdy = 1'b1;
    #1;
    chk("st_rdy_on_pop", 64'(bus.req_rdy), 64'd1);
    chk("st_fwd12", {bus.mem_ce, bus.mem_addr}, {55'd0, 1'b1, 8'd12});
    @(negedge clk);
    drive(1'b0, 1'b0, 8'd0, 64'd0);
    chk("st_val11", 64'(bus.rsp_val), 64'd1);
    chk("st_head11", bus.rsp_data, pat(8'd11));
    @(negedge clk);
    chk("st_val12", 64'(bus.rsp_val), 64'd1);
    chk("st_head12", bus.rsp_data, pat(8'd12));
    @(negedge clk);
    chk("st_drained", 64'(bus.rsp_val), 64'd0);
    // reset while a read is in flight
    drive(1'b1, 1'b0, 8'd3, 64'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'd0, 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mr_rdy", 64'(bus.req_rdy), 64'd0);
    chk("mr_val", 64'(bus.rsp_val), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("mr_noresp%0d", i), 64'(bus.rsp_val), 64'd0);
    end
    // out-of-range read (depth 200)
    drive(1'b1, 1'b0, 8'd250, 64'd0);
    #1;
`ifdef MEM_MASTER_ADDR_CHK_EN
    chk("oor_ce", 64'(bus.mem_ce), 64'd0);
`else
    chk("oor_ce", {bus.mem_ce, bus.mem_addr}, {55'd0, 1'b1, 8'd250});
`endif
    chk("oor_rdy", 64'(bus.req_rdy), 64'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'd0, 64'd0);
`ifdef MEM_MASTER_ADDR_CHK_EN
    chk("oor_err", 64'(bus.err_addr), 64'd1);
`else
    chk("oor_err", 64'(bus.err_addr), 64'd0);
`endif
    chk("oor_lat1", 64'(bus.rsp_val), 64'd0);
    @(negedge clk);
    chk("oor_err_end", 64'(bus.err_addr), 64'd0);
    chk("oor_val", 64'(bus.rsp_val), 64'd1);
`ifdef MEM_MASTER_ADDR_CHK_EN
    chk("oor_data", bus.rsp_data, 64'd0);
`else
    chk("oor_data", bus.rsp_data, pat(8'd250));
`endif
    @(negedge clk);
    chk("oor_single", 64'(bus.rsp_val), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
